// File: rtl/game_pkg.sv
// Shared state encoding, default timing constants and small helpers for the game controller.
package game_pkg;

    localparam int DEB_CNT_DEF     = 500000;
    localparam int INIT_CYCLES_DEF = 16;
    localparam int BLINK_LOG2_DEF  = 24;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    // Game counter stops at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser followed by a reload-on-agreement down-counter debouncer.
// The output level follows the synchronised input only after the two have disagreed
// for DEB_CNT consecutive cycles; any agreement in between reloads the counter.
module button_debounce
    import game_pkg::*;
#(
    parameter int DEB_CNT = DEB_CNT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level
);

    localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DEB_CNT - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Bring the raw button into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Count down while input disagrees with output; flip the level at terminal count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= RELOAD;
        end else if (cnt == '0) begin
            level <= sync2;
            cnt   <= RELOAD;
        end else begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/game_controller.sv
// Game sequencing controller: debounces the three buttons, runs the
// IDLE/INIT/PLAY/OVER flow and drives the ball movement block.
//
//   state | meaning
//   IDLE  | power-up / reset, ball block held in reset, waiting for start
//   INIT  | ball block held in reset for INIT_CYCLES cycles
//   PLAY  | game running, left/right buttons forwarded
//   OVER  | game lost, over_led blinks, waiting for start
module game_controller
    import game_pkg::*;
#(
    parameter int DEB_CNT     = DEB_CNT_DEF,
    parameter int INIT_CYCLES = INIT_CYCLES_DEF,
    parameter int BLINK_LOG2  = BLINK_LOG2_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       over,
    output logic       game_rst,
    output logic       left,
    output logic       right,
    output logic       middle,
    output logic       over_led,
    output logic [7:0] games,
    output logic [1:0] state
);

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [IW-1:0] INIT_RELOAD = IW'(INIT_CYCLES - 1);

    logic                  deb_start;
    logic                  deb_left;
    logic                  deb_right;
    logic                  start_pulse;
    logic [1:0]            state_next;
    logic [IW-1:0]         init_cnt;
    logic [BLINK_LOG2-1:0] blink_cnt;

    button_debounce #(.DEB_CNT(DEB_CNT)) u_deb_start (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_start),
        .level (deb_start)
    );

    button_debounce #(.DEB_CNT(DEB_CNT)) u_deb_left (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_left),
        .level (deb_left)
    );

    button_debounce #(.DEB_CNT(DEB_CNT)) u_deb_right (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_right),
        .level (deb_right)
    );

    // middle is the debounced start level one cycle late, so it doubles as the edge-detect history.
    assign start_pulse = deb_start & ~middle;

    // Next-state decode; over only matters in PLAY, start only in IDLE and OVER.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_pulse)     state_next = ST_INIT;
            ST_INIT: if (init_cnt == '0)  state_next = ST_PLAY;
            ST_PLAY: if (over)            state_next = ST_OVER;
            ST_OVER: if (start_pulse)     state_next = ST_INIT;
            default:                      state_next = ST_IDLE;
        endcase
    end

    // State register, INIT down-counter and saturating games counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            init_cnt <= '0;
            games    <= 8'd0;
        end else begin
            state <= state_next;
            if (state_next == ST_INIT && state != ST_INIT) begin
                init_cnt <= INIT_RELOAD;
            end else if (state == ST_INIT && init_cnt != '0) begin
                init_cnt <= init_cnt - IW'(1);
            end
            if (state == ST_INIT && state_next == ST_PLAY) begin
                games <= sat_inc(games);
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            game_rst <= 1'b1;
            left     <= 1'b0;
            right    <= 1'b0;
            middle   <= 1'b0;
        end else begin
            game_rst <= (state_next == ST_IDLE) || (state_next == ST_INIT);
            left     <= (state_next == ST_PLAY) && deb_left && !deb_right;
            right    <= (state_next == ST_PLAY) && deb_right && !deb_left;
            middle   <= deb_start;
        end
    end

    // Blink counter: cleared with the LED lit on OVER entry, LED flips on every counter wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            over_led  <= 1'b0;
        end else if (state_next == ST_OVER) begin
            if (state != ST_OVER) begin
                blink_cnt <= '0;
                over_led  <= 1'b1;
            end else begin
                blink_cnt <= blink_cnt + BLINK_LOG2'(1);
                if (&blink_cnt) begin
                    over_led <= ~over_led;
                end
            end
        end else begin
            blink_cnt <= '0;
            over_led  <= 1'b0;
        end
    end

endmodule
